// File: rtl/button_event_detector_if.sv
// rtl/button_event_detector_if.sv - button inputs and conditioned event outputs of button_event_detector
interface button_event_detector_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] button;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] out;
  logic [CHANNELS-1:0] repeat_evt;

  modport master (
    output button,
    input  level, rise, fall, out, repeat_evt
  );

  modport slave (
    input  button,
    output level, rise, fall, out, repeat_evt
  );
endinterface

// File: rtl/button_event_detector.sv
// rtl/button_event_detector.sv - per-channel synchroniser, debounce, edge pulses and long-press/auto-repeat
module button_event_detector #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 100,
  parameter int EDGE_MODE       = 1,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000,
  parameter int BTN_ACTIVE_LOW  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  button_event_detector_if.slave bus
);

  localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW       = $clog2(HOLD_MAX + 1);
  localparam int DW       = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST  = (REPEAT_CYCLES > 0) ? HW'(REPEAT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    HELD     = 2'd2,
    DONE     = 2'd3
  } hold_state_e;

  logic [CHANNELS-1:0] s1_q, s1_d;
  logic [CHANNELS-1:0] s2_q, s2_d;
  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] fall_q, fall_d;
  logic [CHANNELS-1:0] out_q, out_d;
  logic [CHANNELS-1:0] repeat_evt_q, repeat_evt_d;
  logic [DW-1:0]       db_cnt_q   [CHANNELS];
  logic [DW-1:0]       db_cnt_d   [CHANNELS];
  logic [HW-1:0]       hold_cnt_q [CHANNELS];
  logic [HW-1:0]       hold_cnt_d [CHANNELS];
  hold_state_e         state_q    [CHANNELS];
  hold_state_e         state_d    [CHANNELS];

  always_comb begin
    s1_d         = bus.button ^ {CHANNELS{BTN_ACTIVE_LOW != 0}};
    s2_d         = s1_q;
    level_d      = level_q;
    rise_d       = '0;
    fall_d       = '0;
    repeat_evt_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      db_cnt_d[i]   = '0;
      hold_cnt_d[i] = hold_cnt_q[i];
      state_d[i]    = state_q[i];

      // Any sample that agrees with the current level restarts the debounce window.
      if (s2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i] = s2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DW'(1);
        end
      end

      rise_d[i] = level_d[i] & ~level_q[i];
      fall_d[i] = ~level_d[i] & level_q[i];

      // Release overrides everything, including a repeat expiring on the same edge.
      if (fall_d[i]) begin
        state_d[i]    = RELEASED;
        hold_cnt_d[i] = '0;
      end else begin
        case (state_q[i])
          RELEASED: begin
            hold_cnt_d[i] = '0;
            if (rise_d[i]) state_d[i] = PRESSED;
          end
          PRESSED: begin
            if (hold_cnt_q[i] == HOLD_LAST) begin
              repeat_evt_d[i] = 1'b1;
              hold_cnt_d[i]   = '0;
              state_d[i]      = (REPEAT_CYCLES > 0) ? HELD : DONE;
            end else begin
              hold_cnt_d[i] = hold_cnt_q[i] + HW'(1);
            end
          end
          HELD: begin
            if (hold_cnt_q[i] == REP_LAST) begin
              repeat_evt_d[i] = 1'b1;
              hold_cnt_d[i]   = '0;
            end else begin
              hold_cnt_d[i] = hold_cnt_q[i] + HW'(1);
            end
          end
          default: begin
            hold_cnt_d[i] = '0;
          end
        endcase
      end
    end

    case (EDGE_MODE)
      0:       out_d = rise_d;
      1:       out_d = fall_d;
      2:       out_d = rise_d | fall_d;
      default: out_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q         <= '0;
      s2_q         <= '0;
      level_q      <= '0;
      rise_q       <= '0;
      fall_q       <= '0;
      out_q        <= '0;
      repeat_evt_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        db_cnt_q[i]   <= '0;
        hold_cnt_q[i] <= '0;
        state_q[i]    <= RELEASED;
      end
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      level_q      <= level_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      out_q        <= out_d;
      repeat_evt_q <= repeat_evt_d;
      for (int i = 0; i < CHANNELS; i++) begin
        db_cnt_q[i]   <= db_cnt_d[i];
        hold_cnt_q[i] <= hold_cnt_d[i];
        state_q[i]    <= state_d[i];
      end
    end
  end

  assign bus.level      = level_q;
  assign bus.rise       = rise_q;
  assign bus.fall       = fall_q;
  assign bus.out        = out_q;
  assign bus.repeat_evt = repeat_evt_q;

endmodule
